// File: rtl/descrypt_sched_pkg.sv
// descrypt_sched shared definitions: core widths, iteration count,
// slot count and scheduler state encoding.
package descrypt_sched_pkg;

  localparam int SALT_MSB = 11;
  localparam int HASH_MSB = 63;
  localparam int DESCRYPT_ITERATIONS = 25;
  localparam int SLOTS = 16;
  localparam int CNT_W = 9;
  localparam int ID_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/descrypt_slot_mem.sv
// descrypt_slot_mem: 16-entry key-id store, written on slot load
// and read back registered on result capture.
module descrypt_slot_mem
  import descrypt_sched_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            wr_en,
  input  logic [3:0]      wr_slot,
  input  logic [ID_W-1:0] wr_id,
  input  logic            rd_en,
  input  logic [3:0]      rd_slot,
  output logic [ID_W-1:0] rd_id
);

  logic [ID_W-1:0] mem [SLOTS];

  // Read sees the old entry when a slot is reloaded in the same cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SLOTS; i++) begin
        mem[i] <= '0;
      end
      rd_id <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_slot] <= wr_id;
      end
      if (rd_en) begin
        rd_id <= mem[rd_slot];
      end
    end
  end

endmodule

// File: rtl/descrypt_sched.sv
// descrypt_sched: batch feeder/collector for the looped descrypt core.
// Optional key-id tracking is enabled by DESCRYPT_SCHED_KEYID_EN.
module descrypt_sched
  import descrypt_sched_pkg::*;
#(
  parameter int ITERATIONS = DESCRYPT_ITERATIONS,
  parameter int SALT_W     = SALT_MSB + 1,
  parameter int HASH_W     = HASH_MSB + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [SALT_W-1:0] salt_in,
  input  logic [55:0]       key56_in,
  input  logic              key_valid,
  output logic              key_rd,
  input  logic              out_ready,
  output logic [SALT_W-1:0] core_salt,
  output logic [55:0]       core_key56,
  output logic              core_valid_in,
  output logic              ENABLE_CRYPT,
  output logic              START_CRYPT,
  input  logic [HASH_W-1:0] core_hash,
  input  logic              core_valid_out,
  output logic [HASH_W-1:0] hash_out,
  output logic              hash_valid,
  output logic [3:0]        hash_slot,
  output logic              busy
`ifdef DESCRYPT_SCHED_KEYID_EN
  ,
  input  logic [ID_W-1:0]   key_id_in,
  output logic [ID_W-1:0]   hash_id_out
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(SLOTS * ITERATIONS - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST =
    CNT_W'(SLOTS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cap_win;
  logic             start_ok;
  logic             at_last;
  logic             drain_end;
  logic             in_win;
  logic             load;
  logic             cap;
  logic             relatch;

  assign start_ok  = key_valid & out_ready;
  assign at_last   = (cnt == CNT_LAST);
  assign drain_end = (cnt == DRAIN_LAST);
  assign in_win    = (cnt[CNT_W-1:4] == '0);
  assign load      = (state == ST_RUN) & in_win;
  assign cap       = cap_win & (state != ST_IDLE)
                   & in_win & core_valid_out;
  assign relatch   = start_ok
                   & ((state == ST_IDLE)
                   | ((state == ST_RUN) & at_last));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == ST_IDLE): begin
        if (start_ok) state_nxt = ST_RUN;
      end
      (state == ST_RUN): begin
        if (at_last && !start_ok) state_nxt = ST_DRAIN;
      end
      (state == ST_DRAIN): begin
        if (drain_end) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ENABLE_CRYPT  = (state != ST_IDLE);
    busy          = (state != ST_IDLE);
    START_CRYPT   = load;
    core_valid_in = load & key_valid;
    key_rd        = load & key_valid;
    core_key56    = load ? key56_in : '0;
  end

  // cap_win marks that the window ahead holds a finished batch.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt       <= '0;
      core_salt <= '0;
      cap_win   <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == ST_RUN):
          cnt <= at_last ? '0 : cnt + 1'b1;
        (state == ST_DRAIN):
          cnt <= drain_end ? '0 : cnt + 1'b1;
        default:
          cnt <= '0;
      endcase
      if (relatch) begin
        core_salt <= salt_in;
      end
      if (state == ST_IDLE) begin
        cap_win <= 1'b0;
      end else if ((state == ST_RUN) && at_last) begin
        cap_win <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hash_out   <= '0;
      hash_valid <= 1'b0;
      hash_slot  <= '0;
    end else begin
      hash_valid <= cap;
      if (cap) begin
        hash_out  <= core_hash;
        hash_slot <= cnt[3:0];
      end
    end
  end

`ifdef DESCRYPT_SCHED_KEYID_EN
  descrypt_slot_mem u_slot_mem (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (key_rd),
    .wr_slot (cnt[3:0]),
    .wr_id   (key_id_in),
    .rd_en   (cap),
    .rd_slot (cnt[3:0]),
    .rd_id   (hash_id_out)
  );
`endif

endmodule

// File: tb/tb_descrypt_sched.sv
// tb_descrypt_sched: directed batches against a delay-line core stub
// and a latency-based result model.
module tb_descrypt_sched;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [11:0] salt_in = '0;
  logic [55:0] key56_in = '0;
  logic        key_valid = 1'b0;
  logic        key_rd;
  logic        out_ready = 1'b0;
  logic [11:0] core_salt;
  logic [55:0] core_key56;
  logic        core_valid_in;
  logic        ENABLE_CRYPT;
  logic        START_CRYPT;
  logic [63:0] core_hash;
  logic        core_valid_out;
  logic [63:0] hash_out;
  logic        hash_valid;
  logic [3:0]  hash_slot;
  logic        busy;
`ifdef DESCRYPT_SCHED_KEYID_EN
  logic [15:0] key_id_in = '0;
  logic [15:0] hash_id_out;
`endif

  always #5 CLK = ~CLK;

  descrypt_sched dut (
    .CLK            (CLK),
    .RST            (RST),
    .salt_in        (salt_in),
    .key56_in       (key56_in),
    .key_valid      (key_valid),
    .key_rd         (key_rd),
    .out_ready      (out_ready),
    .core_salt      (core_salt),
    .core_key56     (core_key56),
    .core_valid_in  (core_valid_in),
    .ENABLE_CRYPT   (ENABLE_CRYPT),
    .START_CRYPT    (START_CRYPT),
    .core_hash      (core_hash),
    .core_valid_out (core_valid_out),
    .hash_out       (hash_out),
    .hash_valid     (hash_valid),
    .hash_slot      (hash_slot),
    .busy           (busy)
`ifdef DESCRYPT_SCHED_KEYID_EN
    ,
    .key_id_in      (key_id_in),
    .hash_id_out    (hash_id_out)
`endif
  );

  function automatic logic [63:0] hfn(input logic [55:0] k,
                                      input logic [11:0] s);
    return {8'h5A, k} ^ {52'd0, s};
  endfunction

  function automatic logic [55:0] kk(input logic [15:0] bid,
                                     input int j);
    return {24'hA5A5A5, bid, 16'(j)};
  endfunction

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int hv_count = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h",
               name, cyc_n, act, exp);
    end
  endtask

  // Core stub: a load reappears 400 enabled cycles later; before the
  // pipe is full it emits garbage with valid set.
  typedef struct packed {
    logic        v;
    logic [63:0] h;
  } ent_t;
  ent_t sq[$];
  ent_t pend;
  bit   pend_en = 1'b0;

  always @(negedge CLK) begin
    pend.v  = START_CRYPT & core_valid_in;
    pend.h  = hfn(core_key56, core_salt);
    pend_en = ENABLE_CRYPT;
  end

  initial begin
    core_valid_out = 1'b0;
    core_hash = '0;
    forever begin
      @(posedge CLK);
      if (pend_en && !RST) sq.push_back(pend);
      else sq.delete();
      if (sq.size() > 400) void'(sq.pop_front());
      #1;
      if (sq.size() == 400) begin
        core_valid_out = sq[0].v;
        core_hash = sq[0].h;
      end else begin
        core_valid_out = 1'b1;
        core_hash = 64'hDEAD_BEEF_0BAD_F00D;
      end
    end
  end

  // Model: outputs follow the batch phase; each popped key yields
  // its hash and slot exactly 401 cycles after the pop.
  typedef struct {
    logic [63:0] h;
    logic [3:0]  s;
`ifdef DESCRYPT_SCHED_KEYID_EN
    logic [15:0] id;
`endif
  } res_t;
  res_t sched[int];
  int phase = 0;
  int t = 0;
  logic [11:0] m_salt = '0;
  logic [63:0] m_hash = '0;
  logic [3:0]  m_slot = '0;
`ifdef DESCRYPT_SCHED_KEYID_EN
  logic [15:0] m_id = '0;
`endif

  always @(negedge CLK) begin
    bit e_start, e_en, e_rd, e_hv;
    logic [55:0] e_key;
    res_t r;
    cyc_n++;
    if (RST) begin
      phase = 0;
      t = 0;
      m_salt = '0;
      m_hash = '0;
      m_slot = '0;
      sched.delete();
`ifdef DESCRYPT_SCHED_KEYID_EN
      m_id = '0;
`endif
    end
    e_en = (phase != 0);
    e_start = (phase == 1) && (t < 16);
    e_rd = e_start && (key_valid === 1'b1);
    e_key = e_start ? key56_in : '0;
    e_hv = !RST && sched.exists(cyc_n);
    if (e_hv) begin
      m_hash = sched[cyc_n].h;
      m_slot = sched[cyc_n].s;
`ifdef DESCRYPT_SCHED_KEYID_EN
      m_id = sched[cyc_n].id;
`endif
      sched.delete(cyc_n);
    end
    if (hash_valid === 1'b1) hv_count++;
    chk("busy", busy, e_en);
    chk("enable", ENABLE_CRYPT, e_en);
    chk("start", START_CRYPT, e_start);
    chk("key_rd", key_rd, e_rd);
    chk("core_valid_in", core_valid_in, e_rd);
    chk("core_key56", core_key56, e_key);
    chk("core_salt", core_salt, m_salt);
    chk("hash_valid", hash_valid, e_hv);
    chk("hash_out", hash_out, m_hash);
    chk("hash_slot", hash_slot, m_slot);
`ifdef DESCRYPT_SCHED_KEYID_EN
    chk("hash_id_out", hash_id_out, m_id);
`endif
    if (!RST) begin
      if (e_rd) begin
        r.h = hfn(key56_in, m_salt);
        r.s = 4'(t);
`ifdef DESCRYPT_SCHED_KEYID_EN
        r.id = 16'h100 + 16'(t);
`endif
        sched[cyc_n + 401] = r;
      end
      case (phase)
        0: if (key_valid && out_ready) begin
          phase = 1;
          t = 0;
          m_salt = salt_in;
        end
        1: if (t == 399) begin
          t = 0;
          if (key_valid && out_ready) m_salt = salt_in;
          else phase = 2;
        end else t++;
        default: if (t == 15) begin
          phase = 0;
          t = 0;
        end else t++;
      endcase
    end
  end

  task automatic cyc(input bit kv, input logic [55:0] k,
                     input logic [11:0] s, input bit r);
    key_valid = kv;
    key56_in = k;
    salt_in = s;
    out_ready = r;
`ifdef DESCRYPT_SCHED_KEYID_EN
    key_id_in = 16'h100 + k[15:0];
`endif
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n, input bit kv, input bit r,
                      input logic [11:0] s);
    repeat (n) cyc(kv, kk(16'hFFFF, 0), s, r);
  endtask

  task automatic batch(input logic [15:0] bid,
                       input logic [15:0] holes,
                       input bit nkv, input bit nrdy,
                       input logic [11:0] nsalt,
                       input logic [15:0] nbid, input int upto);
    for (int j = 0; j < upto; j++) begin
      if (j < 16)
        cyc(!holes[j], kk(bid, j), 12'($urandom), 1'b1);
      else if (j == 399)
        cyc(nkv, kk(nbid, 0), nsalt, nrdy);
      else
        cyc(1'b0, '0, 12'($urandom), 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=done",
             cyc_n);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    idle(3, 1'b0, 1'b1, 12'h0);

    // single full batch
    hv_count = 0;
    cyc(1'b1, kk(16'h1, 0), 12'h123, 1'b1);
    batch(16'h1, 16'h0, 1'b0, 1'b1, 12'h0, 16'h0, 400);
    cyc(1'b0, '0, 12'h0, 1'b1);
    chk("lit_hv0", hash_valid, 1'b1);
    chk("lit_slot0", hash_slot, 4'd0);
    chk("lit_hash0", hash_out, 64'h5AA5A5A500010123);
    chk("lit_salt1", core_salt, 12'h123);
    idle(20, 1'b0, 1'b1, 12'h0);
    chk("lit_idle1", busy, 1'b0);
    chk("lit_cnt1", hv_count, 16);

    // sparse load, holes at slots 3 and 9
    hv_count = 0;
    cyc(1'b1, kk(16'h2, 0), 12'h456, 1'b1);
    batch(16'h2, 16'h0208, 1'b0, 1'b1, 12'h0, 16'h0, 400);
    idle(20, 1'b0, 1'b1, 12'h0);
    chk("lit_cnt2", hv_count, 14);

    // back-to-back batches
    hv_count = 0;
    cyc(1'b1, kk(16'h3, 0), 12'h789, 1'b1);
    batch(16'h3, 16'h0, 1'b1, 1'b1, 12'h3C3, 16'h4, 400);
    chk("lit_salt3", core_salt, 12'h3C3);
    chk("lit_b2b", START_CRYPT, 1'b1);
    batch(16'h4, 16'h0, 1'b0, 1'b1, 12'h0, 16'h0, 400);
    idle(20, 1'b0, 1'b1, 12'h0);
    chk("lit_cnt3", hv_count, 32);

    // out_ready low at the boundary forces DRAIN
    hv_count = 0;
    cyc(1'b1, kk(16'h5, 0), 12'h5A5, 1'b1);
    batch(16'h5, 16'h0, 1'b1, 1'b0, 12'h111, 16'h6, 400);
    chk("lit_drain", START_CRYPT, 1'b0);
    repeat (8) cyc(1'b1, kk(16'h6, 0), 12'h222, 1'b0);
    repeat (8) cyc(1'b1, kk(16'h6, 0), 12'h222, 1'b1);
    idle(5, 1'b1, 1'b0, 12'h333);
    chk("lit_idle4", busy, 1'b0);
    chk("lit_cnt4a", hv_count, 16);
    cyc(1'b1, kk(16'h6, 0), 12'hABC, 1'b1);
    chk("lit_salt4", core_salt, 12'hABC);
    batch(16'h6, 16'h0, 1'b0, 1'b1, 12'h0, 16'h0, 400);
    idle(20, 1'b0, 1'b1, 12'h0);
    chk("lit_cnt4b", hv_count, 32);

    // asynchronous reset mid-batch
    hv_count = 0;
    cyc(1'b1, kk(16'h7, 0), 12'h777, 1'b1);
    batch(16'h7, 16'h0, 1'b0, 1'b1, 12'h0, 16'h0, 200);
    RST = 1'b1;
    #1;
    chk("lit_rst_busy", busy, 1'b0);
    chk("lit_rst_en", ENABLE_CRYPT, 1'b0);
    chk("lit_rst_salt", core_salt, 12'h0);
    chk("lit_rst_hash", hash_out, 64'h0);
    idle(3, 1'b0, 1'b1, 12'h0);
    RST = 1'b0;
    idle(450, 1'b0, 1'b1, 12'h0);
    chk("lit_cnt5a", hv_count, 0);
    cyc(1'b1, kk(16'h8, 0), 12'h888, 1'b1);
    batch(16'h8, 16'h0, 1'b0, 1'b1, 12'h0, 16'h0, 400);
    idle(20, 1'b0, 1'b1, 12'h0);
    chk("lit_cnt5b", hv_count, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/descrypt_sched.md
Name: descrypt_sched

Overview:
- Batch scheduler that sits directly upstream of the 16-round looped descrypt core. It feeds the core and collects what the core produces.
- Feeding: pops keys from an input stream, loads 16 slots per batch with START_CRYPT, and holds ENABLE_CRYPT while the core iterates.
- Collecting: picks up the finished hashes as they leave the core and emits them with slot indices.
- It overlaps loading of the next batch with draining of the current batch, so the core stays fully occupied.

Parameters:
- ITERATIONS, 25, number of passes through the 16-round pipeline per batch (DES crypt count).
- SALT_W, 12, salt width; must equal core `SALT_MSB+1.
- HASH_W, 64, hash width; must equal core `HASH_MSB+1.

Ports:
- CLK  in  1  sole clock.
- RST  in  1  asynchronous, active-high reset.
- salt_in  in  SALT_W  salt for the next batch; sampled only at batch start.
- key56_in  in  56  next key; valid while key_valid=1.
- key_valid  in  1  key56_in holds a key.
- key_rd  out  1  pop strobe; the key is consumed in any cycle with key_rd=1.
- out_ready  in  1  downstream can absorb 16 back-to-back results; no per-result backpressure.
- core_salt  out  SALT_W  latched batch salt.
- core_key56  out  56  key to the core.
- core_valid_in  out  1  slot-valid to the core.
- ENABLE_CRYPT  out  1  core enable.
- START_CRYPT  out  1  core load select.
- core_hash  in  HASH_W  core hash_out.
- core_valid_out  in  1  core valid_out.
- hash_out  out  HASH_W  result hash.
- hash_valid  out  1  one-cycle strobe per valid slot.
- hash_slot  out  4  slot index 0..15 of hash_out.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: every output is 0. State=IDLE, cnt=0, salt latch=0. Asserting RST mid-batch aborts immediately; in-flight hashes are discarded and never emitted.
- States and counter:
  - States are IDLE, RUN and DRAIN.
  - cnt is 9 bits and counts 0..16*ITERATIONS-1 (0..399) in RUN.
  - slot = cnt[3:0].
- IDLE:
  - ENABLE_CRYPT=0.
  - Goes to RUN with cnt=0 when key_valid & out_ready.
  - salt_in is latched into core_salt on that same edge.
- RUN:
  - ENABLE_CRYPT=1.
  - Load window (cnt<16):
    - START_CRYPT=1 and core_key56=key56_in.
    - If key_valid=1: core_valid_in=1 and key_rd=1.
    - If key_valid=0: core_valid_in=0 and key_rd=0; the slot stays empty for this batch and no later refill happens.
  - For cnt>=16: START_CRYPT=0, key_rd=0, core_valid_in=0.
- Batch boundary (cnt=399):
  - If key_valid & out_ready: cnt goes to 0, the state stays RUN (back-to-back batch) and the salt is relatched.
  - Otherwise the state goes to DRAIN with cnt=0.
- DRAIN:
  - ENABLE_CRYPT=1 and START_CRYPT=0; lasts 16 cycles (cnt 0..15).
  - Then goes to IDLE.
  - A key that arrives during DRAIN waits for IDLE and does not restart mid-drain.
- Result capture:
  - Applies in the first 16 cycles following any completed batch, i.e. cnt<16 of the next RUN period or of DRAIN.
  - When core_valid_out=1: hash_out, hash_slot=slot and hash_valid=1 are registered.
  - Result latency is one cycle, so a result appears 16*ITERATIONS+1 cycles after its key_rd.
  - The first batch after IDLE captures nothing in its load window. A capture-window flag qualifies capture and is cleared in IDLE.
- Simultaneous events: in a back-to-back batch, capture of old slot k and load of new slot k happen in the same cycle. This is legal because the core outputs slot k exactly as START_CRYPT overwrites it.
- core_salt is stable for the whole batch, including the DRAIN/capture window of that batch's predecessor. The core salt only affects in-flight rounds, so the relatch on cnt=399->0 is permitted.

Optional Feature:
- DESCRYPT_SCHED_KEYID_EN adds key_id_in (in, 16) and hash_id_out (out, 16).
- With the macro:
  - The id is written to a 16-entry slot register array on each load.
  - It is read out with the matching slot on capture and aligned with hash_valid.
  - It resets to 0.
- Without the macro: the ports and storage are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/header (descrypt.vh): SALT_MSB, HASH_MSB, DESCRYPT_ITERATIONS=25, the state encodings, and SLOTS=16.
- One sub-module, descrypt_slot_mem: the 16-entry id array, instantiated only under DESCRYPT_SCHED_KEYID_EN.

Test Plan:
- Single full batch: 16 keys always valid, out_ready=1 → key_rd high for cycles 0..15, START_CRYPT for 16 cycles, 16 hash_valid strobes with slots 0..15, first strobe 401 cycles after the first key_rd, then DRAIN→IDLE, busy=0.
- Sparse load: key_valid low at slots 3 and 9 → core_valid_in=0 there, key_rd=0 there, exactly 14 results with slots 3 and 9 absent.
- Back-to-back: 32 keys queued → second load overlaps capture of the first batch, START_CRYPT high for cnt 0..15 of both periods, 32 results with no gap, no DRAIN between batches.
- out_ready=0 at cnt=399 → DRAIN taken, first batch's 16 results still emitted, IDLE until out_ready=1, then the new batch starts with the fresh salt_in (e.g. 12'hABC→core_salt).
- RST pulsed at cnt=200 → all outputs 0 asynchronously, no hash_valid afterwards, next batch behaves like the first scenario.
- With DESCRYPT_SCHED_KEYID_EN: ids 0x100+k → hash_id_out=0x100+slot for each result.
